echo_cancel_sub: RTL and testbench
==================================

Name: echo_cancel_sub

Overview:
- Downstream consumer of the echo approximation stage's 3-tap coefficients.
- Builds its own 3-sample far-end history (x0 newest, x1, x2 oldest) and forms echo_est = c0*x0 + c1*x1 + c2*x2.
- Outputs the residual near_sample − echo_est, saturated to 16 bits.
- Streaming, 3-stage pipeline with valid/ready handshake on both sides.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed.
- COEF_FRAC, 14: coefficient fractional bits (Q2.14; 0x4000 = 1.0).
- SATCNT_W, 8: width of the saturation event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  input sample pair valid.
- in_ready  out  1  block accepts an input this cycle.
- far_sample  in  DATA_W  far-end (loudspeaker) sample, signed.
- near_sample  in  DATA_W  near-end (mic, echo-bearing) sample, signed.
- coef_0, coef_1, coef_2  in  COEF_W each  tap coefficients for x0/x1/x2, signed.
- coef_load  in  1  strobe: capture coef_0..2 into internal registers.
- out_valid  out  1  residual valid.
- out_ready  in  1  downstream accepts the residual.
- out_sample  out  DATA_W  residual, signed, saturated.
- sat_count  out  SATCNT_W  number of saturated outputs; sticks at all-ones.

Behaviour:
- Reset (sync, rst=1 at a rising edge) clears everything:
  - out_valid=0, out_sample=0, sat_count=0.
  - History x0..x2 = 0, coefficient registers = 0, all stage valids = 0.
  - in_ready=1 in the first cycle after reset.
  - A reset mid-operation discards in-flight samples; no output is produced for them.
- Stall model: advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance=0, all pipeline registers and the history hold.
- Transfer occurs when in_valid && in_ready. On a transfer:
  - Shift history: x2<=x1, x1<=x0, x0<=far_sample.
  - Capture near_sample; set S1 valid.
- Warm-up: history starts at zero, so the first sample uses x1=x2=0 and the second uses x2=0. No output is suppressed.
- S1→S2: three signed DATA_W×COEF_W products, 32 bits each, using the coefficient registers. Near sample is carried along.
- S2→S3:
  - sum = p0+p1+p2, sign-extended to 34 bits.
  - est = sum >>> COEF_FRAC (arithmetic), 20 bits.
  - diff = sext(near) − est, 21 bits.
  - Saturate to [−32768, 32767]; result registers into out_sample and sets out_valid.
- Latency: 3 cycles from input transfer to out_valid, given no stall. Throughput is 1 sample per cycle.
- Bubbles (no transfer while advance=1) propagate as invalid stages and do not alter the history.
- coef_load:
  - Captures coef_0..2 at the rising edge, regardless of stall state.
  - Products computed in any later cycle use the new values. A sample already past S2 is unaffected.
  - If coef_load and rst are both high, rst wins.
- sat_count increments by 1 on each S3 load whose diff was clipped; it holds at 2^SATCNT_W−1.
- out_sample holds its value while out_valid && !out_ready.

Optional Feature:
- Macro: ECS_ROUND_EN.
- Defined: before the shift, add 2^(COEF_FRAC−1) to sum. Rounding is round-half-up toward +inf.
- Undefined: plain arithmetic shift, i.e. floor / truncation toward −inf. No added logic.

Test Plan:
- Reset behaviour: assert rst 2 cycles → out_valid=0, sat_count=0, in_ready=1, out_sample=0.
- Zero coefficients: far=1000, near=500 → out_sample=500 exactly 3 cycles after the transfer.
- Two-tap cancellation:
  - coef_load with c0=0x4000, c1=0x2000, c2=0.
  - Stream (far,near) = (1000,1000), (2000,2500).
  - Expected outputs: 1000−1000=0, then 2500−(2000+500)=0.
- Saturation:
  - coef_load c0=0x8000 (−2.0); far=20000, near=0 → out_sample=32767, sat_count=1.
  - far=−20000, near=0 → −32768, sat_count=2.
- Backpressure:
  - Stream 6 samples (c0=0x4000, near=0, far=1..6) with out_ready low for 5 cycles mid-stream.
  - Expected: in_ready drops, and outputs −1..−6 arrive in order with no loss or duplication.
- Rounding: c0=0x0001, far=8192, near=10 → out_sample=9 with ECS_ROUND_EN, 10 without.

Source files
------------

// File: rtl/echo_cancel_sub.sv
// rtl/echo_cancel_sub.sv - 3-tap echo estimate subtraction with saturating residual output
// Optional rounding of the echo estimate is enabled by defining ECS_ROUND_EN.
module echo_cancel_sub #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 14,
    parameter int SATCNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   far_sample,
    input  logic signed [DATA_W-1:0]   near_sample,
    input  logic signed [COEF_W-1:0]   coef_0,
    input  logic signed [COEF_W-1:0]   coef_1,
    input  logic signed [COEF_W-1:0]   coef_2,
    input  logic                       coef_load,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_sample,
    output logic [SATCNT_W-1:0]        sat_count
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 2;
    localparam int EST_W  = SUM_W - COEF_FRAC;
    localparam int DIFF_W = EST_W + 1;
    localparam logic signed [DIFF_W-1:0] SAT_MAX = DIFF_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [DIFF_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [COEF_W-1:0] r_c0, r_c1, r_c2;
    logic signed [DATA_W-1:0] r_x0, r_x1, r_x2;
    logic signed [DATA_W-1:0] r_s1_near, r_s2_near;
    logic                     r_s1_valid, r_s2_valid;
    logic signed [PROD_W-1:0] r_p0, r_p1, r_p2;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_sample;
    logic [SATCNT_W-1:0]      r_sat_count;

    logic                     w_advance;
    logic                     w_xfer;
    logic signed [PROD_W-1:0] w_p0, w_p1, w_p2;
    logic signed [SUM_W-1:0]  w_sum, w_sum_rnd;
    logic signed [EST_W-1:0]  w_est;
    logic signed [DIFF_W-1:0] w_diff;
    logic                     w_clip_hi, w_clip_lo;
    logic signed [DATA_W-1:0] w_res;

    assign w_advance = !r_out_valid || out_ready;
    assign w_xfer    = in_valid && w_advance;
    assign in_ready  = w_advance;

    // The history register set always describes the sample sitting in S1.
    assign w_p0 = $signed({{COEF_W{r_x0[DATA_W-1]}}, r_x0}) * $signed({{DATA_W{r_c0[COEF_W-1]}}, r_c0});
    assign w_p1 = $signed({{COEF_W{r_x1[DATA_W-1]}}, r_x1}) * $signed({{DATA_W{r_c1[COEF_W-1]}}, r_c1});
    assign w_p2 = $signed({{COEF_W{r_x2[DATA_W-1]}}, r_x2}) * $signed({{DATA_W{r_c2[COEF_W-1]}}, r_c2});

    assign w_sum = $signed({{2{r_p0[PROD_W-1]}}, r_p0}) + $signed({{2{r_p1[PROD_W-1]}}, r_p1})
                 + $signed({{2{r_p2[PROD_W-1]}}, r_p2});
`ifdef ECS_ROUND_EN
    assign w_sum_rnd = w_sum + $signed(SUM_W'(1) << (COEF_FRAC - 1));
`else
    assign w_sum_rnd = w_sum;
`endif
    assign w_est  = EST_W'(w_sum_rnd >>> COEF_FRAC);
    assign w_diff = $signed({{(DIFF_W - DATA_W){r_s2_near[DATA_W-1]}}, r_s2_near})
                  - $signed({w_est[EST_W-1], w_est});

    assign w_clip_hi = (w_diff > SAT_MAX);
    assign w_clip_lo = (w_diff < SAT_MIN);

    always_comb begin
        w_res = DATA_W'(w_diff);
        if (w_clip_hi) begin
            w_res = SAT_MAX[DATA_W-1:0];
        end else if (w_clip_lo) begin
            w_res = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c0 <= '0;
            r_c1 <= '0;
            r_c2 <= '0;
        end else if (coef_load) begin
            r_c0 <= coef_0;
            r_c1 <= coef_1;
            r_c2 <= coef_2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0         <= '0;
            r_x1         <= '0;
            r_x2         <= '0;
            r_s1_near    <= '0;
            r_s1_valid   <= 1'b0;
            r_p0         <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_s2_near    <= '0;
            r_s2_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_sat_count  <= '0;
        end else if (w_advance) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_x2      <= r_x1;
                r_x1      <= r_x0;
                r_x0      <= far_sample;
                r_s1_near <= near_sample;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_p0      <= w_p0;
                r_p1      <= w_p1;
                r_p2      <= w_p2;
                r_s2_near <= r_s1_near;
            end
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_sample <= w_res;
                if ((w_clip_hi || w_clip_lo) && (r_sat_count != '1)) begin
                    r_sat_count <= r_sat_count + SATCNT_W'(1);
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;
    assign sat_count  = r_sat_count;
endmodule

// File: tb/tb_echo_cancel_sub.sv
// tb/tb_echo_cancel_sub.sv - directed self-checking bench for echo_cancel_sub
module tb_echo_cancel_sub;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] far_sample = '0;
    logic signed [15:0] near_sample = '0;
    logic signed [15:0] coef_0 = '0;
    logic signed [15:0] coef_1 = '0;
    logic signed [15:0] coef_2 = '0;
    logic               coef_load = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_sample;
    logic [7:0]         sat_count;

    int checks = 0;
    int errors = 0;
    int far_q[$];
    int near_q[$];
    int got_q[$];
    bit saw_in_ready_low;

    always #5 clk = ~clk;

    echo_cancel_sub dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .far_sample(far_sample), .near_sample(near_sample),
        .coef_0(coef_0), .coef_1(coef_1), .coef_2(coef_2), .coef_load(coef_load),
        .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
        .sat_count(sat_count)
    );

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_coefs(input int c0, input int c1, input int c2);
        coef_0 = 16'(c0);
        coef_1 = 16'(c1);
        coef_2 = 16'(c2);
        coef_load = 1'b1;
        @(posedge clk);
        #1 coef_load = 1'b0;
    endtask

    // Feeds far_q/near_q, collects accepted outputs into got_q; out_ready low during the stall window.
    task automatic drive_stream(input int stall_start, input int stall_len);
        int sent = 0;
        int cyc = 0;
        got_q.delete();
        saw_in_ready_low = 1'b0;
        while ((sent < far_q.size() || got_q.size() < far_q.size()) && cyc < 600) begin
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            in_valid = (sent < far_q.size());
            if (in_valid) begin
                far_sample  = 16'(far_q[sent]);
                near_sample = 16'(near_q[sent]);
            end
            #1;
            if (!in_ready) saw_in_ready_low = 1'b1;
            if (out_valid && out_ready) got_q.push_back(int'(out_sample));
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (sat_count !== 8'd0) begin errors++; $display("FAIL reset_sat_count got %0d want 0", sat_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_sample !== 16'sd0) begin errors++; $display("FAIL reset_out_sample got %0d want 0", out_sample); end
    endtask

    task automatic test_zero_coef();
        do_reset();
        in_valid = 1'b1;
        far_sample = 16'sd1000;
        near_sample = 16'sd500;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_lat1 got %0b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_lat2 got %0b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_lat3_valid got %0b want 1", out_valid); end
        checks++; if (out_sample !== 16'sd500) begin errors++; $display("FAIL zero_out got %0d want 500", out_sample); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_single got %0b want 0", out_valid); end
    endtask

    task automatic test_two_tap();
        do_reset();
        load_coefs(16'h4000, 16'h2000, 0);
        far_q = '{1000, 2000};
        near_q = '{1000, 2500};
        drive_stream(1000, 0);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL two_tap_count got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] != 0) begin
                errors++; $display("FAIL two_tap_out%0d got %0d want 0", i, (i < got_q.size()) ? got_q[i] : -99999);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        load_coefs(16'h8000, 0, 0);
        far_q = '{20000};
        near_q = '{0};
        drive_stream(1000, 0);
        checks++; if (got_q.size() != 1 || got_q[0] != 32767) begin errors++; $display("FAIL sat_pos got %0d want 32767", (got_q.size() > 0) ? got_q[0] : -99999); end
        checks++; if (sat_count !== 8'd1) begin errors++; $display("FAIL sat_count1 got %0d want 1", sat_count); end
        far_q = '{-20000};
        near_q = '{0};
        drive_stream(1000, 0);
        checks++; if (got_q.size() != 1 || got_q[0] != -32768) begin errors++; $display("FAIL sat_neg got %0d want -32768", (got_q.size() > 0) ? got_q[0] : -99999); end
        checks++; if (sat_count !== 8'd2) begin errors++; $display("FAIL sat_count2 got %0d want 2", sat_count); end
    endtask

    task automatic test_sat_hold();
        do_reset();
        load_coefs(16'h8000, 0, 0);
        far_q.delete();
        near_q.delete();
        for (int i = 0; i < 260; i++) begin
            far_q.push_back(20000);
            near_q.push_back(0);
        end
        drive_stream(1000, 0);
        checks++; if (sat_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", sat_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_coefs(16'h4000, 0, 0);
        far_q = '{1, 2, 3, 4, 5, 6};
        near_q = '{0, 0, 0, 0, 0, 0};
        drive_stream(4, 5);
        checks++; if (saw_in_ready_low !== 1'b1) begin errors++; $display("FAIL bp_in_ready_drop got %0b want 1", saw_in_ready_low); end
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL bp_count got %0d want 6", got_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] != -(i + 1)) begin
                errors++; $display("FAIL bp_out%0d got %0d want %0d", i, (i < got_q.size()) ? got_q[i] : -99999, -(i + 1));
            end
        end
    endtask

    task automatic test_rounding();
        int exp_pos;
        int exp_neg;
`ifdef ECS_ROUND_EN
        exp_pos = 9;
        exp_neg = 10;
`else
        exp_pos = 10;
        exp_neg = 11;
`endif
        do_reset();
        load_coefs(1, 0, 0);
        far_q = '{8192, -8192};
        near_q = '{10, 10};
        drive_stream(1000, 0);
        checks++; if (got_q.size() != 2 || got_q[0] != exp_pos) begin errors++; $display("FAIL round_pos got %0d want %0d", (got_q.size() > 0) ? got_q[0] : -99999, exp_pos); end
        checks++; if (got_q.size() != 2 || got_q[1] != exp_neg) begin errors++; $display("FAIL round_neg got %0d want %0d", (got_q.size() > 1) ? got_q[1] : -99999, exp_neg); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        load_coefs(16'h4000, 0, 0);
        in_valid = 1'b1;
        far_sample = 16'sd50;
        near_sample = 16'sd0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_flush%0d got %0b want 0", i, out_valid); end
            @(posedge clk); #1;
        end
        far_q = '{100};
        near_q = '{7};
        drive_stream(1000, 0);
        checks++; if (got_q.size() != 1 || got_q[0] != 7) begin errors++; $display("FAIL mid_reset_coef_clear got %0d want 7", (got_q.size() > 0) ? got_q[0] : -99999); end
    endtask

    initial begin
        test_reset();
        test_zero_coef();
        test_two_tap();
        test_saturation();
        test_sat_hold();
        test_back_to_back();
        test_rounding();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
